mux_8_scanner: RTL and testbench
================================

# mux_8_scanner

Sequencing stage that sits directly upstream of `mux_8`. It drives the 3-bit `sel` bus through channels 0..7 and samples the single-bit `mux_8` output after a programmable dwell time. The eight samples are assembled into one 8-bit word, which is handed downstream over a valid/ready handshake. Each scan is one-shot on `start`, or free-running when `continuous` is set.

## Interface
- `DWELL`, default 2: clock cycles `sel` is held per channel before sampling; legal range 1..255.
- `DW_W`, default 8: width of the dwell counter; must satisfy DWELL ≤ 2^DW_W − 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; the block has one clock.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `continuous`  in  1  when high at word acceptance, start the next scan immediately.
- `abort`  in  1  synchronous cancel; discards the partial or held word.
- `mux_out`  in  1  output of `mux_8`.
- `sel`  out  3  channel select to `mux_8`; registered.
- `word`  out  8  assembled samples; bit i = channel i (`a` = bit 0, `h` = bit 7).
- `word_valid`  out  1  `word` is held and stable.
- `word_ready`  in  1  downstream accepts `word`.
- `busy`  out  1  high in SCAN or HOLD.

## Operation
- States:
  - IDLE: `sel`=0, `busy`=0.
  - SCAN: `sel`=ch, dwell counting.
  - HOLD: `word_valid`=1.
- IDLE → SCAN on `start`=1. Set ch=0 and dwell count=0.
- SCAN behaviour:
  - The counter increments each cycle.
  - On the cycle where count==DWELL−1, capture `mux_out` into capture-register bit ch.
  - If ch<7, increment ch and clear the count.
  - If ch==7, copy the capture register (including the bit captured this edge) to `word` and go to HOLD.
- HOLD → SCAN (ch=0) on `word_ready`=1 with `continuous`=1. This gives a one-cycle `word_valid` pulse minimum and no extra bubble.
- HOLD → IDLE on `word_ready`=1 with `continuous`=0.
- HOLD without `word_ready`: hold indefinitely. This is backpressure; nothing is dropped and no new sampling occurs.
- `abort`=1 in SCAN or HOLD → IDLE next edge:
  - `word_valid` drops.
  - `word` keeps its last value.
  - The capture register clears.
- `abort` has priority over `word_ready` and `start`. `start` and `abort` are ignored outside IDLE and outside SCAN/HOLD respectively.
- `start` asserted in SCAN or HOLD is ignored, with no queuing.
- `word` changes only on HOLD entry. It is constant for the whole of HOLD and while in IDLE.

## Timing
- Reset values: `sel`=0, `word`=8'h00, `word_valid`=0, `busy`=0, state IDLE, ch=0, count=0, capture register=0.
- Reset asserted mid-scan or mid-HOLD clears everything immediately; no word is emitted.
- `start` sampled at edge E0 produces the following:
  - `sel`=0 and `busy`=1 from E0.
  - Channel k is sampled at edge E0+(k+1)·DWELL.
  - `sel` changes to k+1 on that same edge.
- `word_valid` rises at edge E0+8·DWELL. For DWELL=1 this is 8 cycles; for DWELL=2 it is 16 cycles.
- `mux_8` is combinational. `mux_out` must be valid in the cycle before the sampling edge, which is guaranteed because `sel` is stable for DWELL ≥ 1 cycles.
- Continuous mode with `word_ready` held high gives a throughput of one word per 8·DWELL+1 cycles.
- `sel` never exceeds 7; ch wraps to 0 only through HOLD → SCAN.

## Structure
- Package `mux_8_pkg` holds:
  - the state enum (IDLE, SCAN, HOLD);
  - `NUM_CH`=8;
  - `SEL_W`=3.
- Sub-module `mux_8_dwell_timer`: a DW_W-bit counter with inputs clear/enable and output `done` (count==DWELL−1). Its reset is asynchronous and active-low.
- `mux_8` itself is instantiated beside this block at the top level, not inside it.
- Elaboration check: DWELL ≥ 1.

## Test plan
- Bench wiring: the bench instantiates a real `mux_8` fed by `sel`.
- DWELL=1, a..h=1,0,1,0,0,0,0,1, pulse `start`, `word_ready`=1 → `word_valid` at cycle 8, `word`=8'h85, then IDLE with `busy`=0.
- DWELL=2, one-hot input rotation per channel (a=1 only) → `word`=8'h01. Check that the `sel` sequence 0..7 is each held 2 cycles and that `word_valid` rises at cycle 16.
- Backpressure: `word_ready`=0 for 20 cycles in HOLD, with inputs toggling → `word` is stable and `sel` stays at 7. Then `word_ready`=1 → single acceptance.
- `continuous`=1, `word_ready`=1, inputs changed between scans (8'hFF then 8'h00) → back-to-back words 8'hFF and 8'h00, 9 cycles apart at DWELL=1.
- `abort` at channel 4 → IDLE next cycle, `word_valid`=0, `word` unchanged. The next `start` gives a correct full word.
- `rst_n` low mid-scan (channel 3) → all outputs reset immediately. After release, `start` produces the correct word from channel 0.

Source files
------------

// File: rtl/mux_8_pkg.sv
// Shared types and sizes for the mux_8 channel scanner.
// No logic; constants only.
package mux_8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

endpackage

// File: rtl/mux_8.sv
// Combinational 8:1 single-bit mux; y follows sel with zero latency.
// No flow control.
module mux_8 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       h,
    input  logic [2:0] sel,
    output logic       y
);

    logic [7:0] bus;

    assign bus = {h, g, f, e, d, c, b, a};
    assign y   = bus[sel];

endmodule

// File: rtl/mux_8_dwell_timer.sv
// Per-channel dwell counter; done is high while count == DWELL-1.
// clear wins over enable; no backpressure of its own.
module mux_8_dwell_timer #(
    parameter int DWELL = 2,
    parameter int DW_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [DW_W-1:0] LAST = DW_W'(DWELL - 1);

    logic [DW_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + DW_W'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/mux_8_scanner.sv
// Steps sel through 8 channels, samples mux_out every DWELL cycles, emits an 8-bit word after 8*DWELL cycles.
// The word is held in HOLD until word_ready; no sampling happens while held.
module mux_8_scanner
    import mux_8_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int DW_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy
);

    if (DWELL < 1 || DWELL > (2**DW_W) - 1) begin : g_bad_dwell
        $error("mux_8_scanner: DWELL must be in 1..2**DW_W-1");
    end

    state_t            state;
    logic [SEL_W-1:0]  ch;
    logic [NUM_CH-1:0] cap;
    logic [NUM_CH-1:0] cap_nxt;
    logic              done;
    logic              tmr_clear;
    logic              tmr_en;

    // Count restarts whenever we are not scanning and after every sample.
    assign tmr_en    = (state == SCAN);
    assign tmr_clear = (state != SCAN) || done;

    mux_8_dwell_timer #(
        .DWELL (DWELL),
        .DW_W  (DW_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .done   (done)
    );

    // Lets the final channel's sample land in word on the same edge.
    always_comb begin
        cap_nxt     = cap;
        cap_nxt[ch] = mux_out;
    end

    assign sel = ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= '0;
            cap        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        ch    <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                        ch    <= '0;
                        cap   <= '0;
                        busy  <= 1'b0;
                    end else if (done) begin
                        cap <= cap_nxt;
                        if (ch == LAST_CH) begin
                            word       <= cap_nxt;
                            word_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            ch <= ch + SEL_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state      <= IDLE;
                        ch         <= '0;
                        cap        <= '0;
                        word_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (word_ready) begin
                        word_valid <= 1'b0;
                        ch         <= '0;
                        if (continuous) begin
                            state <= SCAN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    ch         <= '0;
                    word_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_8_scanner.sv
// Directed bench: two scanners (DWELL=1 and DWELL=2), each driving a real mux_8.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_mux_8_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;

    logic       start1 = 0, cont1 = 0, abort1 = 0, ready1 = 0;
    logic       y1, valid1, busy1;
    logic [2:0] sel1;
    logic [7:0] word1;

    logic       start2 = 0, cont2 = 0, abort2 = 0, ready2 = 0;
    logic       y2, valid2, busy2;
    logic [2:0] sel2;
    logic [7:0] word2;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mux_8 u_mux1 (.a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]), .e(din[4]),
                  .f(din[5]), .g(din[6]), .h(din[7]), .sel(sel1), .y(y1));
    mux_8 u_mux2 (.a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]), .e(din[4]),
                  .f(din[5]), .g(din[6]), .h(din[7]), .sel(sel2), .y(y2));

    mux_8_scanner #(.DWELL(1), .DW_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont1), .abort(abort1),
        .mux_out(y1), .sel(sel1), .word(word1), .word_valid(valid1),
        .word_ready(ready1), .busy(busy1)
    );

    mux_8_scanner #(.DWELL(2), .DW_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .continuous(cont2), .abort(abort2),
        .mux_out(y2), .sel(sel2), .word(word2), .word_valid(valid2),
        .word_ready(ready2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until dut1 presents a word; returns the number of edges taken.
    task automatic wait_valid1(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!valid1 && cycles < 40);
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    int cyc;

    initial begin
        #2;
        check("rst_sel",   32'(sel1),   32'h0);
        check("rst_word",  32'(word1),  32'h00);
        check("rst_valid", 32'(valid1), 32'h0);
        check("rst_busy",  32'(busy1),  32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // DWELL=1 basic scan: a..h = 1,0,1,0,0,0,0,1
        din    = 8'h85;
        ready1 = 1'b1;
        pulse_start1();
        check("d1_busy_e0", 32'(busy1), 32'h1);
        check("d1_sel_e0",  32'(sel1),  32'h0);
        wait_valid1(cyc);
        check("d1_latency", 32'(cyc),   32'd8);
        check("d1_word",    32'(word1), 32'h85);
        tick();
        check("d1_valid_drop", 32'(valid1), 32'h0);
        check("d1_busy_idle",  32'(busy1),  32'h0);
        check("d1_word_keep",  32'(word1),  32'h85);

        // DWELL=2: each channel held two cycles, word after 16 edges
        din    = 8'h01;
        ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int t = 0; t <= 16; t++) begin
            if (t > 0) tick();
            check($sformatf("d2_sel_t%0d", t), 32'(sel2), (t / 2 > 7) ? 32'd7 : 32'(t / 2));
            check($sformatf("d2_valid_t%0d", t), 32'(valid2), (t == 16) ? 32'h1 : 32'h0);
        end
        check("d2_word", 32'(word2), 32'h01);
        tick();
        check("d2_busy_idle", 32'(busy2), 32'h0);

        // Backpressure: word and sel frozen while held
        din    = 8'h3C;
        ready1 = 1'b0;
        pulse_start1();
        wait_valid1(cyc);
        check("bp_latency", 32'(cyc), 32'd8);
        for (int i = 0; i < 20; i++) begin
            din = ~din;
            tick();
            check("bp_word",  32'(word1),  32'h3C);
            check("bp_valid", 32'(valid1), 32'h1);
        end
        check("bp_sel", 32'(sel1), 32'h7);
        ready1 = 1'b1;
        tick();
        check("bp_accept_valid", 32'(valid1), 32'h0);
        check("bp_accept_busy",  32'(busy1),  32'h0);
        tick();
        check("bp_no_second", 32'(valid1), 32'h0);

        // Continuous: back-to-back words 9 cycles apart
        din   = 8'hFF;
        cont1 = 1'b1;
        pulse_start1();
        wait_valid1(cyc);
        check("cont_lat1",  32'(cyc),   32'd8);
        check("cont_word1", 32'(word1), 32'hFF);
        din = 8'h00;
        wait_valid1(cyc);
        check("cont_gap",   32'(cyc),   32'd9);
        check("cont_word2", 32'(word1), 32'h00);
        cont1 = 1'b0;
        tick();
        check("cont_end_busy", 32'(busy1), 32'h0);

        // Abort at channel 4
        din = 8'hA5;
        pulse_start1();
        repeat (4) tick();
        check("ab_sel4", 32'(sel1), 32'h4);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("ab_busy",  32'(busy1),  32'h0);
        check("ab_valid", 32'(valid1), 32'h0);
        check("ab_word",  32'(word1),  32'h00);
        check("ab_sel",   32'(sel1),   32'h0);
        pulse_start1();
        wait_valid1(cyc);
        check("ab_rescan_lat",  32'(cyc),   32'd8);
        check("ab_rescan_word", 32'(word1), 32'hA5);
        tick();

        // Asynchronous reset at channel 3
        din = 8'h5A;
        pulse_start1();
        repeat (3) tick();
        check("rs_sel3", 32'(sel1), 32'h3);
        rst_n = 1'b0;
        #1;
        check("rs_sel",   32'(sel1),   32'h0);
        check("rs_word",  32'(word1),  32'h00);
        check("rs_valid", 32'(valid1), 32'h0);
        check("rs_busy",  32'(busy1),  32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("rs_stay_idle", 32'(busy1), 32'h0);
        din = 8'hC3;
        pulse_start1();
        wait_valid1(cyc);
        check("rs_rescan_lat",  32'(cyc),   32'd8);
        check("rs_rescan_word", 32'(word1), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
